fifo_push_arbiter: RTL and testbench
====================================

FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 The block SHALL have parameter NR, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter DW, default 64, data width per entry.
REQ-003 The block SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port RSTn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid  input  NR  per-requester push request, bit k = requester k.
REQ-006 The block SHALL have port req_data  input  NR*DW  requester k data at [DW*k+:DW].
REQ-007 The block SHALL have port req_ready  output  NR  one-hot-or-zero grant; requester k transfers when req_valid[k] & req_ready[k].
REQ-008 The block SHALL have port fifo_push  output  1  push strobe to shared queue.
REQ-009 The block SHALL have port data_push  output  DW  entry presented to shared queue.
REQ-010 The block SHALL have port fifo_full  input  1  shared queue full; push not taken when high.
REQ-011 The block SHALL have port flush  input  1  synchronous flush, shared with the queue.

Function
REQ-012 The block SHALL hold one output slot: out_valid (1 bit) and out_data (DW bits); fifo_push = out_valid & ~flush; data_push = out_data.
REQ-013 The slot SHALL be drained on any cycle with out_valid & ~fifo_full & ~flush.
REQ-014 slot_free SHALL equal ~out_valid | ~fifo_full (full-throughput: refill in the drain cycle).
REQ-015 The block SHALL keep rr_ptr, width clog2(NR), naming the highest-priority requester.
REQ-016 Winner SHALL be the first k with req_valid[k] set, searching rr_ptr, rr_ptr+1, ... wrapping NR-1 -> 0.
REQ-017 req_ready[k] SHALL be 1 only when slot_free & ~flush & k is the winner; req_ready may depend combinationally on req_valid and fifo_full.
REQ-018 On a grant to k, the next cycle SHALL have out_valid=1, out_data=req_data[k], rr_ptr=(k+1) mod NR.
REQ-019 With no grant, rr_ptr SHALL hold; out_valid SHALL clear only if drained.
REQ-020 With fifo_full held high and out_valid=1, out_data, out_valid and rr_ptr SHALL hold and req_ready SHALL be 0.
REQ-021 Flush SHALL take priority over all events: no grant, no push, next cycle out_valid=0, rr_ptr=0; out_data holds.
REQ-022 A requester continuously valid SHALL be granted within NR grants (starvation-free).
REQ-023 Latency SHALL be one cycle from grant to fifo_push; sustained throughput one entry per cycle while fifo_full=0.

Reset
REQ-024 RSTn low SHALL asynchronously set out_valid=0, out_data=0, rr_ptr=0; hence fifo_push=0, data_push=0, req_ready=0 until valid requests after release.
REQ-025 Reset mid-transfer SHALL discard the slot entry without a push.

Configuration
REQ-026 Macro FIFO_ARB_FIXED_PRIO_EN defined: rr_ptr SHALL not be implemented; winner SHALL be the lowest-index valid requester; all other behaviour unchanged.
REQ-027 Macro FIFO_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-015..REQ-022.

Verification (NR=4, DW=64)
REQ-028 After reset, req_valid=4'b1111 with fifo_full=0 for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, fifo_push=1 from cycle 2 on, data_push matching each requester's data.
REQ-029 Slot holds 0xA5, fifo_full=1 for 5 cycles, req_valid=4'b0010 -> req_ready=0, data_push=0xA5 stable; fifo_full drops -> 0xA5 pushed and requester 1 granted same cycle.
REQ-030 rr_ptr=3, req_valid=4'b0101 -> requester 0 granted, rr_ptr becomes 1; next grant requester 2.
REQ-031 out_valid=1, flush=1 with req_valid=4'b1111 -> req_ready=0, fifo_push=0, next cycle out_valid=0, rr_ptr=0.
REQ-032 FIFO_ARB_FIXED_PRIO_EN defined, req_valid=4'b1110 held 3 cycles -> requester 1 granted every cycle.
REQ-033 RSTn asserted with out_valid=1 and fifo_full=1 -> fifo_push=0 immediately, no push after release until a new grant.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: arbitrates NR push requesters into one registered output slot
// that feeds a shared queue. Default arbitration is round-robin; defining
// FIFO_ARB_FIXED_PRIO_EN selects fixed lowest-index-first priority and removes
// the round-robin pointer.
module fifo_push_arbiter #(
  parameter int unsigned NR = 4,
  parameter int unsigned DW = 64
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [NR-1:0]    req_valid,
  input  logic [NR*DW-1:0] req_data,
  output logic [NR-1:0]    req_ready,
  output logic             fifo_push,
  output logic [DW-1:0]    data_push,
  input  logic             fifo_full,
  input  logic             flush
);

  localparam int unsigned PW = (NR > 1) ? $clog2(NR) : 1;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          slot_free;
  logic          grant;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [DW-1:0] win_data;

`ifndef FIFO_ARB_FIXED_PRIO_EN
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // The slot can accept a new entry if empty or if it drains this very cycle.
  assign slot_free = ~out_valid_q | ~fifo_full;
  assign grant     = slot_free & ~flush & win_found;
  assign win_data  = req_data[DW*win_idx +: DW];

  assign fifo_push = out_valid_q & ~flush;
  assign data_push = out_data_q;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Winner search: lowest-index valid requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < int'(NR); i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = PW'(i);
      end
    end
  end
`else
  // Winner search: first valid requester starting at rr_ptr, wrapping NR-1 -> 0.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < int'(NR); i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= int'(NR)) begin
        cand = cand - int'(NR);
      end
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  // Pointer moves past the winner on a grant and returns to 0 on flush.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (grant) begin
      rr_ptr_d = (win_idx == PW'(NR - 1)) ? '0 : win_idx + PW'(1);
    end
  end
`endif

  // One-hot grant to the winner, gated by slot availability and flush.
  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Slot next state: flush clears, a grant refills, otherwise drain when the queue accepts.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
    end else if (out_valid_q && !fifo_full) begin
      out_valid_d = 1'b0;
    end
  end

  // Slot and pointer state, cleared asynchronously so a pending entry is discarded.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter (NR=4, DW=64): directed scenarios then random traffic,
// all checked against a transaction-level model of the output slot and arbiter.
module tb_fifo_push_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;

  logic             CLK;
  logic             RSTn;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             fifo_push;
  logic [DW-1:0]    data_push;
  logic             fifo_full;
  logic             flush;

  int n_chk;
  int n_err;

  // Model: slot contents and the requester currently holding top priority.
  bit          m_valid;
  logic [63:0] m_data;
  int          m_ptr;

  fifo_push_arbiter #(
    .NR(NR),
    .DW(DW)
  ) u_dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .fifo_push(fifo_push),
    .data_push(data_push),
    .fifo_full(fifo_full),
    .flush    (flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < NR; k++) begin
      req_data[DW*k +: DW] = {$urandom, $urandom};
    end
  endtask

  // Priority order the model scans, highest first.
  function automatic int prio_at(input int i);
`ifdef FIFO_ARB_FIXED_PRIO_EN
    return i;
`else
    return (m_ptr + i) % NR;
`endif
  endfunction

  // Drive one cycle of inputs, compare outputs against the model, advance one clock.
  task automatic step(input logic [3:0] rv, input logic full, input logic fl,
                      output logic [3:0] gnt);
    bit          found;
    int          w;
    logic [3:0]  e_ready;
    bit          n_valid;
    logic [63:0] n_data;
    int          n_ptr;
    req_valid = rv;
    fifo_full = full;
    flush     = fl;
    #1;
    found = 0;
    w     = 0;
    for (int i = 0; i < NR; i++) begin
      if (!found && rv[prio_at(i)]) begin
        found = 1;
        w     = prio_at(i);
      end
    end
    e_ready = ((!m_valid || !full) && !fl && found) ? 4'(1 << w) : 4'b0000;
    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("fifo_push", 64'(fifo_push), 64'(m_valid && !fl));
    check("data_push", data_push, m_data);
    gnt = req_ready;
    n_valid = m_valid;
    n_data  = m_data;
    n_ptr   = m_ptr;
    if (fl) begin
      n_valid = 0;
      n_ptr   = 0;
    end else if (e_ready != 4'b0000) begin
      n_valid = 1;
      n_data  = req_data[DW*w +: DW];
      n_ptr   = (w + 1) % NR;
    end else if (m_valid && !full) begin
      n_valid = 0;
    end
    @(posedge CLK);
    #1;
    m_valid = n_valid;
    m_data  = n_data;
    m_ptr   = n_ptr;
  endtask

  // Assert reset mid-cycle, check outputs immediately, release one edge later.
  task automatic do_reset();
    req_valid = '0;
    flush     = 1'b0;
    RSTn      = 1'b0;
    #1;
    m_valid = 0;
    m_data  = '0;
    m_ptr   = 0;
    check("rst_fifo_push", 64'(fifo_push), 64'd0);
    check("rst_data_push", data_push, 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  initial begin
    logic [3:0] g;
    n_chk     = 0;
    n_err     = 0;
    RSTn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    flush     = 1'b0;
    m_valid   = 0;
    m_data    = '0;
    m_ptr     = 0;
    @(posedge CLK);
    #1;
    do_reset();

    // All requesters valid, queue never full: one grant per cycle in rotation.
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step(4'b1111, 1'b0, 1'b0, g);
`ifndef FIFO_ARB_FIXED_PRIO_EN
      check("rr_order", 64'(g), 64'(1 << (i % NR)));
`endif
      if (i > 0) check("stream_push", 64'(fifo_push), 64'd1);
    end
    step(4'b0000, 1'b0, 1'b0, g);
    step(4'b0000, 1'b0, 1'b0, g);

    // Backpressure: slot holds 0xA5 while full, then drains and refills in one cycle.
    req_data[DW*1 +: DW] = 64'hA5;
    step(4'b0010, 1'b1, 1'b0, g);
    check("a5_grant", 64'(g), 64'b0010);
    req_data[DW*1 +: DW] = 64'hB6;
    for (int i = 0; i < 5; i++) begin
      step(4'b0010, 1'b1, 1'b0, g);
      check("full_hold_ready", 64'(g), 64'd0);
      check("full_hold_data", data_push, 64'hA5);
    end
    fifo_full = 1'b0;
    #1;
    check("drain_push", 64'(fifo_push), 64'd1);
    check("drain_data", data_push, 64'hA5);
    step(4'b0010, 1'b0, 1'b0, g);
    check("drain_regrant", 64'(g), 64'b0010);
    check("refill_data", data_push, 64'hB6);
    step(4'b0000, 1'b0, 1'b0, g);

`ifndef FIFO_ARB_FIXED_PRIO_EN
    // Pointer wrap: grant to 2 leaves the pointer at 3; 0101 then picks 0, then 2.
    rand_data();
    step(4'b0100, 1'b0, 1'b0, g);
    step(4'b0101, 1'b0, 1'b0, g);
    check("wrap_grant0", 64'(g), 64'b0001);
    step(4'b0101, 1'b0, 1'b0, g);
    check("wrap_grant2", 64'(g), 64'b0100);
`else
    // Fixed priority: requester 1 wins every cycle against 2 and 3.
    for (int i = 0; i < 3; i++) begin
      rand_data();
      step(4'b1110, 1'b0, 1'b0, g);
      check("fixed_grant1", 64'(g), 64'b0010);
    end
`endif

    // Flush with a full slot and all requesters valid.
    rand_data();
    step(4'b0010, 1'b0, 1'b0, g);
    step(4'b1111, 1'b0, 1'b1, g);
    check("flush_ready", 64'(g), 64'd0);
    flush = 1'b0;
    req_valid = '0;
    #1;
    check("flush_cleared", 64'(fifo_push), 64'd0);
    step(4'b1111, 1'b0, 1'b0, g);
    check("flush_ptr0", 64'(g), 64'b0001);

    // Reset with a pending entry held by backpressure: entry is discarded.
    step(4'b0000, 1'b1, 1'b0, g);
    check("pre_rst_push", 64'(fifo_push), 64'd1);
    #2;
    do_reset();
    step(4'b0000, 1'b0, 1'b0, g);
    check("post_rst_push", 64'(fifo_push), 64'd0);

    // Random traffic with occasional backpressure, flush and held request sets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rv;
      rand_data();
      rv = 4'($urandom_range(0, 15));
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        step(rv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), g);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
